// File: rtl/engine_result_accumulator.sv
// Accumulates per-PE engine results over a programmable number of steps with
// signed saturation, then offers the finished vector over a valid/ready port.
module engine_result_accumulator #(
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned PE_NUM       = 4,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter int unsigned STEP_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [STEP_W-1:0]                    num_steps,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PE_NUM-1:0][RESULT_WIDTH-1:0]  result_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PE_NUM-1:0][ACC_WIDTH-1:0]     out_data,
  output logic [PE_NUM-1:0]                    sat_flag,
  output logic                                 busy
);

  localparam int unsigned EXT_W = ACC_WIDTH + 1 - RESULT_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                           state_q, state_d;
  logic [STEP_W-1:0]                cnt_q, steps_q;
  logic [PE_NUM-1:0][ACC_WIDTH-1:0] acc_q, acc_nxt_c;
  logic [PE_NUM-1:0]                sat_q, ovf_c;
  logic                             in_ready_q, out_valid_q, busy_q;
  logic                             arm_c, beat_c, last_c;

  // A job is armed from IDLE, or from HOLD only together with the output handshake.
  assign arm_c  = start && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign beat_c = (state_q == ACCUM) && in_valid;
  assign last_c = beat_c && (cnt_q == steps_q - STEP_W'(1));

  // Per-lane add one bit wider than the accumulator; a differing top pair means overflow.
  for (genvar p = 0; p < int'(PE_NUM); p++) begin : g_lane
    logic [ACC_WIDTH:0] ext_in;
    logic [ACC_WIDTH:0] sum;
    assign ext_in = {{EXT_W{result_in[p][RESULT_WIDTH-1]}}, result_in[p]};
    assign sum    = {acc_q[p][ACC_WIDTH-1], acc_q[p]} + ext_in;
    assign ovf_c[p] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign acc_nxt_c[p] = ovf_c[p] ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                   : sum[ACC_WIDTH-1:0];
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last_c) state_d = HOLD;
      HOLD:    if (out_ready) state_d = start ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus state-decoded handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Job datapath: arming clears everything, each beat adds one result vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
    end else if (arm_c) begin
      acc_q   <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
      steps_q <= (num_steps == '0) ? STEP_W'(1) : num_steps;
    end else if (beat_c) begin
      acc_q   <= acc_nxt_c;
      sat_q   <= sat_q | ovf_c;
      cnt_q   <= cnt_q + STEP_W'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_engine_result_accumulator.sv
// Directed bench: two accumulators (24-bit and 20-bit) share one stimulus stream.
module tb_engine_result_accumulator;

  localparam int unsigned RW = 16;
  localparam int unsigned PN = 4;
  localparam int unsigned SW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [SW-1:0] num_steps;
  logic in_valid;
  logic out_ready;
  logic [PN-1:0][RW-1:0] result_in;

  logic in_ready_a, out_valid_a, busy_a;
  logic in_ready_b, out_valid_b, busy_b;
  logic [PN-1:0][23:0] out_a;
  logic [PN-1:0][19:0] out_b;
  logic [PN-1:0] sat_a, sat_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  engine_result_accumulator #(.RESULT_WIDTH(RW), .PE_NUM(PN), .ACC_WIDTH(24), .STEP_W(SW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
    .in_valid(in_valid), .in_ready(in_ready_a), .result_in(result_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_a),
    .sat_flag(sat_a), .busy(busy_a));

  engine_result_accumulator #(.RESULT_WIDTH(RW), .PE_NUM(PN), .ACC_WIDTH(20), .STEP_W(SW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
    .in_valid(in_valid), .in_ready(in_ready_b), .result_in(result_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_b),
    .sat_flag(sat_b), .busy(busy_b));

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input int r0, input int r1, input int r2, input int r3);
    result_in[0] = RW'(r0);
    result_in[1] = RW'(r1);
    result_in[2] = RW'(r2);
    result_in[3] = RW'(r3);
  endtask

  task automatic beat(input int r0, input int r1, input int r2, input int r3);
    set_res(r0, r1, r2, r3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Both instances must hold the same (non-saturating) vector.
  task automatic chk_vec(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_a%0d", tag, p), int'($signed(out_a[p])), e[p]);
      chk($sformatf("%s_b%0d", tag, p), int'($signed(out_b[p])), e[p]);
    end
  endtask

  task automatic chk_ctl(input string tag, input int rdy, input int vld, input int bsy);
    chk({tag, "_in_ready"},  int'(in_ready_a),  rdy);
    chk({tag, "_out_valid"}, int'(out_valid_a), vld);
    chk({tag, "_busy"},      int'(busy_a),      bsy);
    chk({tag, "_in_ready_b"},  int'(in_ready_b),  rdy);
    chk({tag, "_out_valid_b"}, int'(out_valid_b), vld);
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    num_steps = SW'(n);
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_steps = '0; in_valid = 1'b0; out_ready = 1'b0;
    set_res(0, 0, 0, 0);
    tick(); tick();
    chk_ctl("reset", 0, 0, 0);
    chk("reset_sat", int'(sat_a), 0);
    chk_vec("reset_data", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Basic three-beat job
    start_job(3);
    chk_ctl("basic_accum", 1, 0, 1);
    beat(1, 2, 3, 4);
    beat(10, 20, 30, 40);
    chk_ctl("basic_mid", 1, 0, 1);
    beat(-5, -5, -5, -5);
    chk_ctl("basic_hold", 0, 1, 1);
    chk_vec("basic", 6, 17, 28, 39);
    chk("basic_sat", int'(sat_a), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_ctl("basic_idle", 0, 0, 0);

    // Same job with stalls; junk data on non-valid cycles must be ignored
    start_job(3);
    beat(1, 2, 3, 4);
    set_res(99, 99, 99, 99);
    chk_ctl("stall1", 1, 0, 1);
    tick();
    chk_ctl("stall2", 1, 0, 1);
    tick();
    beat(10, 20, 30, 40);
    set_res(-99, -99, -99, -99);
    chk_ctl("stall3", 1, 0, 1);
    tick();
    beat(-5, -5, -5, -5);
    for (int i = 0; i < 5; i++) begin
      chk_ctl($sformatf("backpress%0d", i), 0, 1, 1);
      chk_vec($sformatf("backpress%0d", i), 6, 17, 28, 39);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_ctl("stall_idle", 0, 0, 0);

    // num_steps == 0 behaves as a single beat
    start_job(0);
    beat(7, -7, 0, 1);
    chk_ctl("zero_steps", 0, 1, 1);
    chk_vec("zero_steps", 7, -7, 0, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // start during ACCUM is ignored
    start_job(2);
    start = 1'b1;
    num_steps = SW'(9);
    beat(1, 1, 1, 1);
    start = 1'b0;
    chk_ctl("start_in_accum", 1, 0, 1);
    beat(2, 2, 2, 2);
    chk_ctl("start_in_accum_done", 0, 1, 1);
    chk_vec("start_in_accum", 3, 3, 3, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Saturation: 255 beats; 24-bit lanes fit, 20-bit lanes clamp
    start_job(255);
    set_res(32767, -32768, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    in_valid = 1'b0;
    chk_ctl("sat_hold", 0, 1, 1);
    chk("sat_a_lane0", int'($signed(out_a[0])), 8355585);
    chk("sat_a_lane1", int'($signed(out_a[1])), -8355840);
    chk("sat_a_flags", int'(sat_a), 0);
    chk("sat_b_lane0", int'($signed(out_b[0])), 524287);
    chk("sat_b_lane1", int'($signed(out_b[1])), -524288);
    chk("sat_b_lane2", int'($signed(out_b[2])), 0);
    chk("sat_b_flags", int'(sat_b), 3);

    // Back-to-back: start with the output handshake re-arms without a bubble
    out_ready = 1'b1;
    start = 1'b1;
    num_steps = SW'(2);
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk_ctl("b2b_accum", 1, 0, 1);
    chk("b2b_sat_cleared", int'(sat_b), 0);
    chk_vec("b2b_cleared", 0, 0, 0, 0);
    beat(5, 6, 7, 8);
    beat(1, 1, 1, 1);
    chk_ctl("b2b_hold", 0, 1, 1);
    chk_vec("b2b", 6, 7, 8, 9);
    chk("b2b_sat", int'(sat_b), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_ctl("b2b_idle", 0, 0, 0);

    // Asynchronous reset in the middle of a job
    start_job(5);
    beat(1, 2, 3, 4);
    beat(1, 2, 3, 4);
    chk("pre_reset_lane3", int'($signed(out_a[3])), 8);
    #1 rst_n = 1'b0;
    #1;
    chk_ctl("async_reset", 0, 0, 0);
    chk_vec("async_reset", 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    tick();
    start_job(1);
    beat(1, 1, 1, 1);
    chk_ctl("post_reset_hold", 0, 1, 1);
    chk_vec("post_reset", 1, 1, 1, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_ctl("post_reset_idle", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/engine_result_accumulator.md
# engine_result_accumulator

Downstream stage of the engine: consumes the per-PE `result_out` vector that the engine produces each step and accumulates it over a programmable number of weight steps. The signed sums are saturated to a wider accumulator width. The finished vector is presented to the writeback path over a valid/ready handshake. Sits between the engine slave's result port and the output buffer writer.

## Interface
Parameters:
- `RESULT_WIDTH`, 16: width of one signed engine result.
- `PE_NUM`, 4: number of PEs (result lanes).
- `ACC_WIDTH`, 24: signed accumulator width; must be greater than `RESULT_WIDTH`.
- `STEP_W`, 8: width of the step-count field.

Ports:
- `clk`, input, 1: clock; the block uses this single clock only.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: begin a new accumulation job; sampled only when accepted.
- `num_steps`, input, `STEP_W`: number of result beats in the job; latched on start; 0 is treated as 1.
- `in_valid`, input, 1: `result_in` holds a valid beat.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `result_in`, input, `[PE_NUM-1:0][RESULT_WIDTH-1:0]`: signed per-PE engine results.
- `out_valid`, output, 1: `out_data` holds a finished vector.
- `out_ready`, input, 1: consumer accepts `out_data`.
- `out_data`, output, `[PE_NUM-1:0][ACC_WIDTH-1:0]`: signed accumulated sums.
- `sat_flag`, output, `PE_NUM`: sticky per-lane saturation indicator for the current job.
- `busy`, output, 1: asserted whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - `start`=1 latches `max(num_steps,1)` into `steps_q`.
  - Clears all accumulators, the step counter and `sat_flag`.
  - Next state is ACCUM.
- ACCUM:
  - A beat is a cycle with `in_valid`=1 and `in_ready`=1.
  - Per lane, each beat computes acc + sign-extend(`result_in[p]`).
  - If the sum exceeds 2^(ACC_WIDTH-1)-1, clamp to that maximum and set `sat_flag[p]`. If the sum is below -2^(ACC_WIDTH-1), clamp to that minimum and set `sat_flag[p]`.
  - Lanes are independent.
  - The step counter increments on each beat. The beat where counter == `steps_q`-1 is the last beat; the next state is HOLD.
- HOLD:
  - `out_data` = accumulators.
  - Holds until `out_ready`=1.
  - On that handshake: if `start`=1 in the same cycle, the job is re-armed as in IDLE and the next state is ACCUM. Otherwise the next state is IDLE.
- `start` is ignored in ACCUM, and ignored in HOLD unless the handshake also occurs.
- `in_valid` is ignored outside ACCUM; no beat is consumed there.
- `sat_flag` stays valid through HOLD. It is cleared only by an accepted start or by reset.

## Timing
- `in_ready` = (state==ACCUM), decoded from registered state with no combinational path from the inputs.
- `out_valid` = (state==HOLD), also registered-state only.
- Latency: last beat at cycle t gives `out_valid`=1 at t+1 with the final sums, including the last beat.
- Minimum job length is `steps_q`+1 cycles from start acceptance to `out_valid`.
- Back-to-back jobs: start together with the output handshake gives `in_ready`=1 on the next cycle, with no idle bubble.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` stay stable.
- Reset values: state IDLE, accumulators 0, `out_data` 0, `out_valid` 0, `in_ready` 0, `busy` 0, `sat_flag` 0, step counter 0.
- Reset asserted mid-job discards all partial sums immediately, without waiting for a clock edge.
- Counter wrap cannot occur: the maximum of 2^STEP_W-1 beats ends the job before the counter overflows.

## Test plan
- Basic job, PE_NUM=4: start with `num_steps`=3; beats {1,2,3,4}, {10,20,30,40}, {-5,-5,-5,-5} → `out_valid` one cycle after beat 3; `out_data`={6,17,28,39}; `sat_flag`=0.
- Stalls: the same job with `in_valid` toggling 1,0,0,1,0,1 → identical sums; `in_ready` high throughout ACCUM. Hold `out_ready`=0 for 5 cycles → `out_data` stable, then one handshake and return to IDLE.
- Saturation, ACC_WIDTH=24: `num_steps`=255 with lane0=32767 every beat → lane0=8355585, no saturation. Repeat with ACC_WIDTH=20 → lane0 clamps to 524287 and `sat_flag[0]`=1. Lane1=-32768 every beat clamps to -524288 and `sat_flag[1]`=1.
- Edge counts: `num_steps`=0 → behaves as 1; a single beat {7,-7,0,1} gives `out_data`={7,-7,0,1}. Assert `start` in ACCUM → ignored; the counter is unaffected.
- Back-to-back: `start` in the same cycle as the output handshake with `num_steps`=2 → ACCUM next cycle; accumulators and `sat_flag` cleared; the second job's sums are independent of the first.
- Reset mid-job: `rst_n` low after 2 of 5 beats → all outputs 0 asynchronously. A new start with 1 beat {1,1,1,1} → `out_data`={1,1,1,1}.
